// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer between the LVDS receiver and the 8b/10b decoder.
// Hunts for a comma using receiver bit-slips, verifies it, then watches decoder code errors.
module lvds_align_ctrl #(
    parameter logic [7:0]  COMMA_PAT  = 8'hBC,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned SLIP_HI    = 2,
    parameter int unsigned SLIP_GAP   = 8,
    parameter int unsigned HUNT_WIN   = 64,
    parameter int unsigned VERIFY_N   = 4,
    parameter int unsigned MAX_SLIP   = 8,
    parameter int unsigned ERR_WIN    = 256,
    parameter int unsigned ERR_MAX    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_locked,
    input  logic [7:0] rx_out,
    input  logic       code_err,
    output logic       rx_data_align,
    output logic       align_done,
    output logic [3:0] slip_cnt,
    output logic       align_fail,
    output logic [7:0] realign_cnt
);
    localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned HiW     = (SLIP_HI > 1) ? $clog2(SLIP_HI) : 1;
    localparam int unsigned GapW    = (SLIP_GAP > 1) ? $clog2(SLIP_GAP) : 1;
    localparam int unsigned WinW    = (HUNT_WIN > 1) ? $clog2(HUNT_WIN) : 1;
    localparam int unsigned VerW    = (VERIFY_N > 1) ? $clog2(VERIFY_N) : 1;
    localparam int unsigned ErrWinW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
    localparam int unsigned ErrCntW = (ERR_MAX > 1) ? $clog2(ERR_MAX) : 1;

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);
    localparam logic [HiW-1:0]     HiLast     = HiW'(SLIP_HI - 1);
    localparam logic [GapW-1:0]    GapLast    = GapW'(SLIP_GAP - 1);
    localparam logic [WinW-1:0]    WinLast    = WinW'(HUNT_WIN - 1);
    localparam logic [VerW-1:0]    VerLast    = VerW'(VERIFY_N - 1);
    localparam logic [ErrWinW-1:0] ErrWinLast = ErrWinW'(ERR_WIN - 1);
    localparam logic [ErrCntW-1:0] ErrCntLast = ErrCntW'(ERR_MAX - 1);

    typedef enum logic [2:0] {
        StIdle, StSettle, StHunt, StSlip, StGap, StVerify, StAligned
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [HiW-1:0]     hi_q, hi_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [WinW-1:0]    win_q, win_d;
    logic [VerW-1:0]    ver_q, ver_d;
    logic [ErrWinW-1:0] err_win_q, err_win_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic               seen_q, seen_d;
    logic [3:0]         slip_cnt_q, slip_cnt_d;
    logic [7:0]         realign_q, realign_d;
    logic               fail_q, fail_d;
    logic               align_q, done_q;

    logic       lock_s;
    logic       seen;
    logic       win_last;
    logic       miss;
    logic [7:0] realign_inc;

    assign lock_s      = sync_q[1];
    assign seen        = seen_q | (rx_out == COMMA_PAT);
    assign win_last    = (win_q == WinLast);
    assign realign_inc = (realign_q == 8'hFF) ? realign_q : realign_q + 8'd1;

    // Every counter defaults to zero, so each state starts its count fresh on entry.
    always_comb begin
        state_d    = state_q;
        settle_d   = '0;
        hi_d       = '0;
        gap_d      = '0;
        win_d      = '0;
        ver_d      = '0;
        err_win_d  = '0;
        err_cnt_d  = '0;
        seen_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        realign_d  = realign_q;
        fail_d     = 1'b0;
        miss       = 1'b0;

        case (state_q)
            StIdle: begin
                slip_cnt_d = '0;
                if (lock_s) state_d = StSettle;
            end
            StSettle: begin
                if (settle_q == SettleLast) state_d = StHunt;
                else settle_d = settle_q + 1'b1;
            end
            StHunt: begin
                if (!win_last) begin
                    win_d  = win_q + 1'b1;
                    seen_d = seen;
                end else if (seen) begin
                    state_d = StVerify;
                end else begin
                    miss = 1'b1;
                end
            end
            StSlip: begin
                if (hi_q == HiLast) state_d = StGap;
                else hi_d = hi_q + 1'b1;
            end
            StGap: begin
                if (gap_q == GapLast) state_d = StHunt;
                else gap_d = gap_q + 1'b1;
            end
            StVerify: begin
                if (!win_last) begin
                    win_d  = win_q + 1'b1;
                    seen_d = seen;
                    ver_d  = ver_q;
                end else if (!seen) begin
                    miss = 1'b1;
                end else if (ver_q == VerLast) begin
                    state_d = StAligned;
                end else begin
                    ver_d = ver_q + 1'b1;
                end
            end
            StAligned: begin
                // The threshold check comes first so a window wrap cannot hide the last error.
                if (code_err && (err_cnt_q == ErrCntLast)) begin
                    state_d    = StHunt;
                    slip_cnt_d = '0;
                    realign_d  = realign_inc;
                end else if (err_win_q != ErrWinLast) begin
                    err_win_d = err_win_q + 1'b1;
                    err_cnt_d = err_cnt_q + ErrCntW'(code_err);
                end
            end
            default: state_d = StIdle;
        endcase

        if (miss) begin
            if ({28'd0, slip_cnt_q} < MAX_SLIP) begin
                state_d = StSlip;
                if (slip_cnt_q != 4'hF) slip_cnt_d = slip_cnt_q + 4'd1;
            end else begin
                state_d    = StSettle;
                slip_cnt_d = '0;
                fail_d     = 1'b1;
            end
        end

        if (!lock_s) begin
            state_d    = StIdle;
            slip_cnt_d = '0;
            fail_d     = 1'b0;
            realign_d  = (state_q == StAligned) ? realign_inc : realign_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sync_q     <= 2'b00;
            settle_q   <= '0;
            hi_q       <= '0;
            gap_q      <= '0;
            win_q      <= '0;
            ver_q      <= '0;
            err_win_q  <= '0;
            err_cnt_q  <= '0;
            seen_q     <= 1'b0;
            slip_cnt_q <= '0;
            realign_q  <= '0;
            fail_q     <= 1'b0;
            align_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], rx_locked};
            settle_q   <= settle_d;
            hi_q       <= hi_d;
            gap_q      <= gap_d;
            win_q      <= win_d;
            ver_q      <= ver_d;
            err_win_q  <= err_win_d;
            err_cnt_q  <= err_cnt_d;
            seen_q     <= seen_d;
            slip_cnt_q <= slip_cnt_d;
            realign_q  <= realign_d;
            fail_q     <= fail_d;
            align_q    <= (state_d == StSlip);
            done_q     <= (state_d == StAligned);
        end
    end

    assign rx_data_align = align_q;
    assign align_done    = done_q;
    assign slip_cnt      = slip_cnt_q;
    assign align_fail    = fail_q;
    assign realign_cnt   = realign_q;

endmodule

// File: doc/lvds_align_ctrl.md
Name: lvds_align_ctrl

Overview:
Word-alignment sequencer for the LVDS receive path.
- Waits for the LVDS receiver PLL to lock.
- Hunts for a comma word on the raw deserialised byte and issues bit-slip pulses on rx_data_align until the comma appears.
- Confirms the alignment, then releases align_done, which is the decoder's reset release.
- Monitors decoder code errors and re-runs alignment when the link degrades.
- Sits between the LVDS receiver and the 8b/10b decoder, clocked by the receiver's rx_outclock.

Parameters:
COMMA_PAT, 8'hBC, raw rx_out pattern that marks alignment
SETTLE_CYC, 16, cycles to wait after lock (synchronised) before hunting
SLIP_HI, 2, cycles rx_data_align is held high per slip (receiver needs at least 2)
SLIP_GAP, 8, cycles to wait after a slip pulse before sampling again
HUNT_WIN, 64, cycles per observation window
VERIFY_N, 4, consecutive windows that must each contain at least one comma
MAX_SLIP, 8, slips allowed per attempt (one per bit position)
ERR_WIN, 256, error-monitor window length in cycles
ERR_MAX, 4, code errors within one ERR_WIN that force realignment

Ports:
clk  in  1  rx_outclock of the LVDS receiver
rst  in  1  asynchronous reset, active-high
rx_locked  in  1  receiver PLL lock; asynchronous, synchronised internally with 2 flops
rx_out  in  8  raw parallel word from the receiver
code_err  in  1  decoder code-error strobe; only meaningful while align_done=1
rx_data_align  out  1  bit-slip request to the receiver
align_done  out  1  alignment achieved; drives the decoder's active-low reset
slip_cnt  out  4  slips issued in the current attempt
align_fail  out  1  one-cycle pulse when MAX_SLIP is exhausted without a comma
realign_cnt  out  8  saturating count of losses of alignment since reset

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; synchroniser flops 0.
- Registered outputs; align_done and rx_data_align are driven by flops, not decoded combinationally.
- States:
  - IDLE: go to SETTLE when synchronised lock = 1 (2 cycles after rx_locked rises). slip_cnt cleared.
  - SETTLE: count SETTLE_CYC cycles, then go to HUNT.
  - HUNT: observe one HUNT_WIN window.
    - If rx_out==COMMA_PAT in any cycle, go to VERIFY at the end of the window.
    - Otherwise go to SLIP if slip_cnt<MAX_SLIP.
    - Otherwise pulse align_fail, clear slip_cnt, and go to SETTLE (retry forever).
  - SLIP: rx_data_align=1 for exactly SLIP_HI cycles; slip_cnt increments (saturating at 15) on entry; then go to GAP.
  - GAP: rx_data_align=0 for SLIP_GAP cycles; then go to HUNT (fresh window).
  - VERIFY: observe VERIFY_N consecutive HUNT_WIN windows.
    - A window without a comma goes to SLIP under the same MAX_SLIP rule as HUNT.
    - When all VERIFY_N windows pass, go to ALIGNED.
  - ALIGNED: align_done=1 from the first cycle in this state. The error counter counts code_err cycles.
    - Error counter and window counter both clear every ERR_WIN cycles.
    - Reaching ERR_MAX within one window: align_done=0 next cycle, realign_cnt+1, slip_cnt cleared, go to HUNT.
- Lock loss: synchronised lock = 0 in any state takes it to IDLE next cycle. align_done and rx_data_align go 0, slip_cnt clears. realign_cnt increments only if the state was ALIGNED.
- Lock loss during SLIP truncates the pulse immediately; a slip pulse is never extended.
- code_err is ignored outside ALIGNED (the decoder is held in reset there).
- Simultaneous events: ERR_MAX reached on the last cycle of a window triggers realignment; the window clear does not mask it. Lock loss has priority over every other transition.
- Window counters wrap to 0 at each window end; every counter is sized by $clog2 of its parameter.

Test Plan:
- rx_locked rises, rx_out constant 8'hBC -> align_done=1 exactly 2+16+64+4*64=338 cycles after rx_locked; no rx_data_align pulses; slip_cnt=0.
- rx_out shows 8'hBC only after 3 slips (bench model rotates the word per slip) -> three 2-cycle rx_data_align pulses, each separated by the 8-cycle gap plus a 64-cycle window; slip_cnt=3 on align_done.
- rx_out never equals 8'hBC -> 8 slips, then a one-cycle align_fail pulse, slip_cnt back to 0, hunting restarts after SETTLE; align_done stays 0 throughout.
- ALIGNED, inject 4 code_err strobes within 256 cycles -> align_done=0 the next cycle, realign_cnt=1; 3 strobes per window sustained over several windows -> align_done remains 1.
- rx_locked drops mid-SLIP (second cycle of the pulse) -> rx_data_align=0 within 3 cycles, state IDLE, slip_cnt=0; relock realigns normally.
- Assert rst while ALIGNED -> all outputs 0 asynchronously, including realign_cnt.
